// File: rtl/climate_pkg.sv
// Shared codes for the climate actuator driver: command encodings, duty levels,
// drive FSM state encoding and the request decoder.
package climate_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_MANUAL = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    HCS_HEAT     = 2'd0,
    HCS_COOL     = 2'd1,
    HCS_STOP     = 2'd2,
    HCS_STOP_ALT = 2'd3
  } hcs_e;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HEAT = 2'd1,
    ST_COOL = 2'd2,
    ST_DEAD = 2'd3
  } drv_state_e;

  localparam logic [1:0] LEVEL0 = 2'd0;
  localparam logic [1:0] LEVEL1 = 2'd1;
  localparam logic [1:0] LEVEL2 = 2'd2;
  localparam logic [1:0] LEVEL3 = 2'd3;

  // Only AUTO and MANUAL may run actuators; the reserved code behaves as IDLE.
  function automatic logic mode_active(input logic [1:0] mode);
    logic active;
    if ((mode == MODE_AUTO) || (mode == MODE_MANUAL)) begin
      active = 1'b1;
    end else begin
      active = 1'b0;
    end
    return active;
  endfunction

  // A stop request is expressed as ST_OFF.
  function automatic drv_state_e decode_req(input logic [1:0] mode, input logic [1:0] hcs);
    drv_state_e req;
    if (!mode_active(mode) || (hcs == HCS_STOP) || (hcs == HCS_STOP_ALT)) begin
      req = ST_OFF;
    end else if (hcs == HCS_HEAT) begin
      req = ST_HEAT;
    end else begin
      req = ST_COOL;
    end
    return req;
  endfunction

endpackage

// File: rtl/climate_actuator_driver_pwm_gen.sv
// PWM timebase: free-running period counter, wrap strobe, and duty comparisons
// evaluated on the counter's next value so the caller can register aligned outputs.
module pwm_gen
  import climate_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] level_next,
  output logic       wrap,
  output logic       hi_next,
  output logic       purge_next
);

  localparam int unsigned CW  = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] QUARTER = CW'(PWM_PERIOD / 4);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [CW:0]   thresh_s;

  assign wrap       = (cnt_r == CNT_MAX);
  assign cnt_next_s = wrap ? '0 : (cnt_r + CW'(1));
  assign purge_next = (cnt_next_s < QUARTER);
  assign hi_next    = ({1'b0, cnt_next_s} < thresh_s);

  // Duty threshold; one bit wider so level 3 reaches a full period (always high).
  always_comb begin
    case (level_next)
      LEVEL0:  thresh_s = CW1'(PWM_PERIOD / 4);
      LEVEL1:  thresh_s = CW1'(PWM_PERIOD / 2);
      LEVEL2:  thresh_s = CW1'((3 * PWM_PERIOD) / 4);
      default: thresh_s = CW1'(PWM_PERIOD);
    endcase
  end

  // Free-running period counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/climate_actuator_driver.sv
// Climate actuator driver: dwell/dead-time protected heat/cool FSM, one-step duty
// ramp, and registered glitch-free heater/cooler/fan/humidifier drive.
module climate_actuator_driver
  import climate_pkg::*;
#(
  parameter int unsigned PWM_PERIOD   = 100,
  parameter int unsigned MIN_DWELL    = 1000,
  parameter int unsigned DEAD_TIME    = 200,
  parameter int unsigned RAMP_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [1:0] heat_cool_stop,
  input  logic [1:0] level,
  input  logic       ultrasonic_mode,
  output logic       heater_pwm,
  output logic       cooler_pwm,
  output logic       fan_pwm,
  output logic       humidifier_en,
  output logic [1:0] drv_state,
  output logic [1:0] applied_level
);

  localparam int unsigned DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam int unsigned TW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam int unsigned RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_TIME - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_PERIODS - 1);

  drv_state_e    state_r;
  drv_state_e    state_next_s;
  drv_state_e    req_s;
  logic [DW-1:0] dwell_r;
  logic [DW-1:0] dwell_next_s;
  logic [TW-1:0] dead_r;
  logic [TW-1:0] dead_next_s;
  logic [RW-1:0] ramp_r;
  logic [RW-1:0] ramp_next_s;
  logic [1:0]    level_r;
  logic [1:0]    level_next_s;
  logic          wrap_s;
  logic          hi_next_s;
  logic          purge_next_s;
  logic          heater_r;
  logic          cooler_r;
  logic          fan_r;
  logic          hum_r;
  logic          heater_next_s;
  logic          cooler_next_s;
  logic          fan_next_s;
  logic          hum_next_s;

  assign req_s = decode_req(mode, heat_cool_stop);

  pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm_gen (
    .clk        (clk),
    .reset      (reset),
    .level_next (level_next_s),
    .wrap       (wrap_s),
    .hi_next    (hi_next_s),
    .purge_next (purge_next_s)
  );

  // Drive FSM next state with dwell and dead-time counters.
  always_comb begin
    state_next_s = state_r;
    dwell_next_s = dwell_r;
    dead_next_s  = dead_r;
    case (state_r)
      ST_OFF: begin
        dwell_next_s = '0;
        dead_next_s  = '0;
        if (req_s != ST_OFF) begin
          state_next_s = req_s;
        end else begin
          state_next_s = ST_OFF;
        end
      end
      ST_HEAT, ST_COOL: begin
        // Direction changes are dropped, not queued, until the dwell has elapsed.
        if (dwell_r == DWELL_MAX) begin
          if (req_s != state_r) begin
            state_next_s = ST_DEAD;
            dead_next_s  = '0;
          end else begin
            state_next_s = state_r;
          end
        end else begin
          dwell_next_s = dwell_r + DW'(1);
        end
      end
      ST_DEAD: begin
        if (dead_r == DEAD_LAST) begin
          state_next_s = ST_OFF;
        end else begin
          dead_next_s = dead_r + TW'(1);
        end
      end
      default: begin
        state_next_s = ST_OFF;
      end
    endcase
  end

  // Duty ramp: one step toward the requested level every RAMP_PERIODS wraps.
  always_comb begin
    level_next_s = level_r;
    ramp_next_s  = ramp_r;
    if (state_r == ST_OFF) begin
      level_next_s = LEVEL0;
      ramp_next_s  = '0;
    end else if (wrap_s) begin
      if (level_r == level) begin
        ramp_next_s = '0;
      end else if (ramp_r == RAMP_LAST) begin
        ramp_next_s = '0;
        if (level > level_r) begin
          level_next_s = level_r + 2'd1;
        end else begin
          level_next_s = level_r - 2'd1;
        end
      end else begin
        ramp_next_s = ramp_r + RW'(1);
      end
    end else begin
      level_next_s = level_r;
    end
  end

  // Output decode from next-cycle state so drives line up with drv_state.
  always_comb begin
    heater_next_s = hi_next_s && (state_next_s == ST_HEAT);
    cooler_next_s = hi_next_s && (state_next_s == ST_COOL);
    hum_next_s    = ultrasonic_mode && mode_active(mode) && (state_next_s != ST_DEAD);
    case (state_next_s)
      ST_HEAT, ST_COOL: fan_next_s = hi_next_s;
      ST_DEAD:          fan_next_s = purge_next_s;
      default:          fan_next_s = 1'b0;
    endcase
  end

  // State, counters and registered drive outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_OFF;
      dwell_r  <= '0;
      dead_r   <= '0;
      ramp_r   <= '0;
      level_r  <= LEVEL0;
      heater_r <= 1'b0;
      cooler_r <= 1'b0;
      fan_r    <= 1'b0;
      hum_r    <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      dwell_r  <= dwell_next_s;
      dead_r   <= dead_next_s;
      ramp_r   <= ramp_next_s;
      level_r  <= level_next_s;
      heater_r <= heater_next_s;
      cooler_r <= cooler_next_s;
      fan_r    <= fan_next_s;
      hum_r    <= hum_next_s;
    end
  end

  assign heater_pwm    = heater_r;
  assign cooler_pwm    = cooler_r;
  assign fan_pwm       = fan_r;
  assign humidifier_en = hum_r;
  assign drv_state     = state_r;
  assign applied_level = level_r;

endmodule
